// File: rtl/apb4_requester_pkg.sv
// Shared types and constants for the APB4 requester: FSM states, APB field
// widths, and the command/response bundles used by the block and its users.
package apb4_requester_pkg;

    // Transfer phases of one APB4 transaction.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int PSTRB_W    = 4;
    localparam int PDATA_W    = 32;
    localparam int PPROT_W    = 3;
    // Widest address a command bundle can carry; the block itself uses G_ADDR_WIDTH.
    localparam int ADDR_MAX_W = 32;

    typedef struct packed {
        logic                  write;
        logic [ADDR_MAX_W-1:0] addr;
        logic [PDATA_W-1:0]    wdata;
        logic [PSTRB_W-1:0]    strb;
        logic [PPROT_W-1:0]    prot;
    } cmd_t;

    typedef struct packed {
        logic [PDATA_W-1:0] rdata;
        logic               slverr;
        logic               timeout;
    } rsp_t;

    // Pass data through only when it belongs to the current direction,
    // otherwise return zero (write data on reads, read data on writes).
    function automatic logic [PDATA_W-1:0] gate_data(input logic               keep,
                                                     input logic [PDATA_W-1:0] data);
        return keep ? data : '0;
    endfunction

endpackage

// File: rtl/apb4_requester.sv
// APB4 requester: turns one valid/ready command into a single SETUP/ACCESS
// transfer and hands read data plus error/timeout status back on a
// valid/ready response port. Every output comes straight from a flop.
module apb4_requester
    import apb4_requester_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 3,
    parameter int G_TIMEOUT    = 16,
    parameter int G_TO_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [PDATA_W-1:0]      cmd_wdata,
    input  logic [PSTRB_W-1:0]      cmd_strb,
    input  logic [PPROT_W-1:0]      cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_W-1:0]      rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,

    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [PPROT_W-1:0]      m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [PDATA_W-1:0]      m_apb_pwdata,
    output logic [PSTRB_W-1:0]      m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [PDATA_W-1:0]      m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [PPROT_W-1:0]      pprot_q, pprot_d;
    logic [G_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [PDATA_W-1:0]      pwdata_q, pwdata_d;
    logic [PSTRB_W-1:0]      pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    rsp_t                    rsp_q, rsp_d;

    // High in the ACCESS cycle whose edge gives up on a silent completer.
    logic                    timeout_hit;

    generate
        if (G_TIMEOUT != 0) begin : g_timeout
            localparam logic [G_TO_WIDTH-1:0] TO_LAST = G_TO_WIDTH'(G_TIMEOUT - 1);

            logic [G_TO_WIDTH-1:0] cnt_q, cnt_d;

            assign timeout_hit = (state_q == ACCESS) && !m_apb_pready && (cnt_q == TO_LAST);

            // Count ACCESS cycles spent waiting; restart every SETUP.
            always_comb begin
                cnt_d = cnt_q;
                if (state_q == SETUP) begin
                    cnt_d = '0;
                end else if ((state_q == ACCESS) && !m_apb_pready && !timeout_hit) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Wait counter register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pprot_d     = pprot_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    // Reads drive neither data nor strobes onto the bus.
                    pwrite_d = cmd_write;
                    pprot_d  = cmd_prot;
                    paddr_d  = cmd_addr;
                    pwdata_d = gate_data(cmd_write, cmd_wdata);
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready completer wins over a timeout firing on the same edge.
                if (m_apb_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.rdata   = gate_data(!pwrite_q, m_apb_prdata);
                    rsp_d.slverr  = m_apb_pslverr;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_d.rdata   = '0;
                    rsp_d.slverr  = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_d.slverr  = 1'b0;
                    rsp_d.timeout = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that it reads 0 throughout reset and rises one
        // cycle after release.
        cmd_ready_d = (state_d == IDLE);
    end

    // State, bus and response registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pprot_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pprot_q     <= pprot_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_q.rdata;
    assign rsp_slverr    = rsp_q.slverr;
    assign rsp_timeout   = rsp_q.timeout;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_pprot   = pprot_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb4_requester.sv
// Directed plus randomized bench for apb4_requester with a transaction-level
// reference model of latency, bus contents and response status.
module tb_apb4_requester;
    import apb4_requester_pkg::*;

    localparam int AW = 3;
    localparam int TO = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic          m_apb_psel;
    logic          m_apb_penable;
    logic          m_apb_pwrite;
    logic [2:0]    m_apb_pprot;
    logic [AW-1:0] m_apb_paddr;
    logic [31:0]   m_apb_pwdata;
    logic [3:0]    m_apb_pstrb;
    logic          m_apb_pready = 1'b0;
    logic [31:0]   m_apb_prdata = '0;
    logic          m_apb_pslverr = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    apb4_requester #(
        .G_ADDR_WIDTH(AW),
        .G_TIMEOUT   (TO),
        .G_TO_WIDTH  (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_strb     (cmd_strb),
        .cmd_prot     (cmd_prot),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_slverr   (rsp_slverr),
        .rsp_timeout  (rsp_timeout),
        .m_apb_psel   (m_apb_psel),
        .m_apb_penable(m_apb_penable),
        .m_apb_pwrite (m_apb_pwrite),
        .m_apb_pprot  (m_apb_pprot),
        .m_apb_paddr  (m_apb_paddr),
        .m_apb_pwdata (m_apb_pwdata),
        .m_apb_pstrb  (m_apb_pstrb),
        .m_apb_pready (m_apb_pready),
        .m_apb_prdata (m_apb_prdata),
        .m_apb_pslverr(m_apb_pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random command traffic that must be ignored while the block is busy.
    task automatic junk_cmd();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    task automatic chk_apb(input string ph, input logic [AW-1:0] a, input logic w,
                           input logic [31:0] pw, input logic [3:0] ps, input logic [2:0] pp);
        chk({ph, "_paddr"},  32'(m_apb_paddr),  32'(a));
        chk({ph, "_pwrite"}, 32'(m_apb_pwrite), 32'(w));
        chk({ph, "_pwdata"}, m_apb_pwdata,      pw);
        chk({ph, "_pstrb"},  32'(m_apb_pstrb),  32'(ps));
        chk({ph, "_pprot"},  32'(m_apb_pprot),  32'(pp));
    endtask

    // One complete transaction: issue c, let the completer wait `waits`
    // ACCESS cycles before answering with (rd, err), stall the response for
    // `stall` cycles, then hand it off. Expectations come from the APB4
    // transfer rules, not from the DUT.
    task automatic do_txn(input cmd_t c, input int waits, input logic err,
                          input logic [31:0] rd, input int stall);
        logic          exp_to;
        int            exp_lat;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_pw;
        logic [3:0]    exp_ps;
        int            lat;
        int            k;

        exp_to    = (waits >= TO);
        exp_lat   = exp_to ? (TO + 2) : (waits + 3);
        exp_rdata = (exp_to || c.write) ? 32'd0 : rd;
        exp_err   = exp_to ? 1'b1 : err;
        exp_addr  = c.addr[AW-1:0];
        exp_pw    = c.write ? c.wdata : 32'd0;
        exp_ps    = c.write ? c.strb : 4'd0;

        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = exp_addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        cmd_prot  = c.prot;
        step();
        junk_cmd();
        lat = 1;
        chk("setup_psel",    32'(m_apb_psel),    32'd1);
        chk("setup_penable", 32'(m_apb_penable), 32'd0);
        chk("cmd_ready_busy", 32'(cmd_ready),    32'd0);
        chk_apb("setup", exp_addr, c.write, exp_pw, exp_ps, c.prot);

        k = 0;
        while (!rsp_valid && lat < 40) begin
            if (m_apb_penable) begin
                chk("access_psel", 32'(m_apb_psel), 32'd1);
                chk_apb("access", exp_addr, c.write, exp_pw, exp_ps, c.prot);
                if (k >= waits) begin
                    m_apb_pready  = 1'b1;
                    m_apb_prdata  = rd;
                    m_apb_pslverr = err;
                end else begin
                    m_apb_pready  = 1'b0;
                    m_apb_prdata  = $urandom;
                    m_apb_pslverr = 1'($urandom_range(0, 1));
                end
                k++;
            end else begin
                m_apb_pready  = 1'b0;
                m_apb_prdata  = $urandom;
                m_apb_pslverr = 1'($urandom_range(0, 1));
            end
            junk_cmd();
            step();
            lat++;
        end
        m_apb_pready = 1'b0;

        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_valid",   32'(rsp_valid),     32'd1);
        chk("rsp_rdata",   rsp_rdata,          exp_rdata);
        chk("rsp_slverr",  32'(rsp_slverr),    32'(exp_err));
        chk("rsp_timeout", 32'(rsp_timeout),   32'(exp_to));
        chk("rsp_psel",    32'(m_apb_psel),    32'd0);
        chk("rsp_penable", 32'(m_apb_penable), 32'd0);

        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            junk_cmd();
            step();
            chk("stall_valid",     32'(rsp_valid),   32'd1);
            chk("stall_rdata",     rsp_rdata,        exp_rdata);
            chk("stall_slverr",    32'(rsp_slverr),  32'(exp_err));
            chk("stall_timeout",   32'(rsp_timeout), 32'(exp_to));
            chk("stall_cmd_ready", 32'(cmd_ready),   32'd0);
            chk("stall_psel",      32'(m_apb_psel),  32'd0);
        end

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("done_valid",     32'(rsp_valid),   32'd0);
        chk("done_slverr",    32'(rsp_slverr),  32'd0);
        chk("done_timeout",   32'(rsp_timeout), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready),   32'd1);
        chk("done_psel",      32'(m_apb_psel),  32'd0);
    endtask

    initial begin
        cmd_t c;

        // Reset state
        step();
        chk("rst_cmd_ready", 32'(cmd_ready),     32'd0);
        chk("rst_psel",      32'(m_apb_psel),    32'd0);
        chk("rst_penable",   32'(m_apb_penable), 32'd0);
        chk("rst_pwrite",    32'(m_apb_pwrite),  32'd0);
        chk("rst_paddr",     32'(m_apb_paddr),   32'd0);
        chk("rst_pwdata",    m_apb_pwdata,       32'd0);
        chk("rst_pstrb",     32'(m_apb_pstrb),   32'd0);
        chk("rst_pprot",     32'(m_apb_pprot),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),     32'd0);
        chk("rst_rdata",     rsp_rdata,          32'd0);
        chk("rst_slverr",    32'(rsp_slverr),    32'd0);
        chk("rst_timeout",   32'(rsp_timeout),   32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write, zero wait states
        c = '{write: 1'b1, addr: 32'h4, wdata: 32'hA5A5_1234, strb: 4'hF, prot: 3'd0};
        do_txn(c, 0, 1'b0, 32'h1111_2222, 0);

        // Read, three wait states; bogus strobes/wdata must not reach the bus
        c = '{write: 1'b0, addr: 32'h6, wdata: 32'hFFFF_FFFF, strb: 4'hA, prot: 3'd5};
        do_txn(c, 3, 1'b0, 32'hDEAD_BEEF, 0);

        // Completer error, with a short response stall
        c = '{write: 1'b1, addr: 32'h2, wdata: 32'h0BAD_F00D, strb: 4'h3, prot: 3'd2};
        do_txn(c, 1, 1'b1, 32'h0, 2);

        // Timeout: completer never ready
        c = '{write: 1'b0, addr: 32'h1, wdata: 32'h0, strb: 4'h0, prot: 3'd1};
        do_txn(c, 100, 1'b0, 32'h1234_5678, 0);

        // Backpressure for 5 cycles, then a read of address 0 right after
        c = '{write: 1'b0, addr: 32'h3, wdata: 32'h0, strb: 4'h0, prot: 3'd7};
        do_txn(c, 0, 1'b0, 32'hCAFE_0001, 5);
        c = '{write: 1'b0, addr: 32'h0, wdata: 32'h0, strb: 4'h0, prot: 3'd0};
        do_txn(c, 0, 1'b0, 32'h0000_ABCD, 0);

        // Ready on the last permitted cycle beats the timeout
        c = '{write: 1'b0, addr: 32'h5, wdata: 32'h0, strb: 4'h0, prot: 3'd3};
        do_txn(c, TO - 1, 1'b1, 32'h5555_AAAA, 1);

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 3'd7;
        cmd_wdata = 32'h7777_7777;
        cmd_strb  = 4'hF;
        cmd_prot  = 3'd6;
        step();
        cmd_valid = 1'b0;
        m_apb_pready = 1'b0;
        step();
        chk("pre_reset_penable", 32'(m_apb_penable), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_psel",      32'(m_apb_psel),    32'd0);
        chk("mid_rst_penable",   32'(m_apb_penable), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready),     32'd0);
        chk("mid_rst_paddr",     32'(m_apb_paddr),   32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid),     32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("after_rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("after_rst_cmd_ready", 32'(cmd_ready),  32'd1);
        chk("after_rst_psel",      32'(m_apb_psel), 32'd0);
        c = '{write: 1'b1, addr: 32'h7, wdata: 32'h1357_9BDF, strb: 4'h6, prot: 3'd4};
        do_txn(c, 2, 1'b0, 32'h0, 0);

        // Randomized traffic, wait counts straddling the timeout limit
        for (int i = 0; i < 30; i++) begin
            c.write = 1'($urandom_range(0, 1));
            c.addr  = 32'($urandom_range(0, 7));
            c.wdata = $urandom;
            c.strb  = 4'($urandom);
            c.prot  = 3'($urandom);
            do_txn(c, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
